// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// MULTICYCLE_ADDER_SUB_EN adds the sub_i operand-side control bit.
interface multicycle_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;
`ifdef MULTICYCLE_ADDER_SUB_EN
    logic             sub_i;

    modport slave (
        input  valid_i, add1_i, add2_i, ready_i, sub_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
    modport master (
        output valid_i, add1_i, add2_i, ready_i, sub_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );
`else
    modport slave (
        input  valid_i, add1_i, add2_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
    modport master (
        output valid_i, add1_i, add2_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );
`endif
endinterface

// File: rtl/multicycle_adder.sv
// Bit-serial-by-slice adder: SLICE bits per cycle, LSB slice first, valid/ready on both sides.
// Optional subtract mode (sub_i) is built when MULTICYCLE_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair (ready_o=1 once out of reset)
// BUSY  | adding one slice per cycle, N cycles
// DONE  | result presented, held until ready_i
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic                clk,
    input logic                rst_n,
    multicycle_adder_if.slave  bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, a_msb_q, b_msb_q;
    logic             valid_q, rdy_q, cout_q, ovf_q;

    logic [SLICE:0]         slice_s;
    logic [WIDTH+SLICE-1:0] cat_s;
    logic [WIDTH-1:0]       sum_full;
    logic [WIDTH-1:0]       b_in;
    logic                   c_in;
    logic                   accept;

    always_comb begin
        slice_s  = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
        cat_s    = {slice_s[SLICE-1:0], acc_q};
        sum_full = cat_s[WIDTH+SLICE-1:SLICE];
`ifdef MULTICYCLE_ADDER_SUB_EN
        // Subtraction is a + ~b + 1: invert b and seed the carry.
        b_in = bus.sub_i ? ~bus.add2_i : bus.add2_i;
        c_in = bus.sub_i;
`else
        b_in = bus.add2_i;
        c_in = 1'b0;
`endif
    end

    // rdy_q keeps ready_o low for the reset cycle; DONE passes ready_i through for back-to-back.
    assign bus.ready_o    = rdy_q | ((state_q == DONE) & bus.ready_i);
    assign accept         = bus.valid_i & bus.ready_o;
    assign bus.valid_o    = valid_q;
    assign bus.sum_o      = sum_q;
    assign bus.carry_o    = cout_q;
    assign bus.overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        a_q     <= bus.add1_i;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        a_msb_q <= bus.add1_i[WIDTH-1];
                        b_msb_q <= b_in[WIDTH-1];
                        rdy_q   <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    acc_q   <= sum_full;
                    carry_q <= slice_s[SLICE];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        sum_q   <= sum_full;
                        cout_q  <= slice_s[SLICE];
                        ovf_q   <= (a_msb_q == b_msb_q) && (sum_full[WIDTH-1] != a_msb_q);
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            a_q     <= bus.add1_i;
                            b_q     <= b_in;
                            carry_q <= c_in;
                            cnt_q   <= '0;
                            a_msb_q <= bus.add1_i[WIDTH-1];
                            b_msb_q <= b_in[WIDTH-1];
                            state_q <= BUSY;
                        end else begin
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// Randomized self-checking bench for multicycle_adder against an integer-arithmetic model.
module tb_multicycle_adder;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

    multicycle_adder #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns {overflow, carry, sum} computed with 64-bit integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint ua, ub, sa, sb, ur, sr;
        logic   c, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            c  = ur[32];
            sr = sa + sb;
        end
        ov = (sr > 64'sh7fffffff) || (sr < -64'sh80000000);
        return {ov, c, ur[31:0]};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        bus.add1_i  = a;
        bus.add2_i  = b;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 50 && !bus.ready_o; i++) @(negedge clk);
        if (!bus.ready_o) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input string tag);
        logic [33:0] exp;
        int          lat;
        exp = model(a, b, s);
        bus.ready_i = (hold == 0);
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub_i = s;
`endif
        drive(a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        for (int i = 0; i < hold; i++) @(negedge clk);
        if (hold > 0) check({tag, "_rdy_hold"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_sum"}, 64'(bus.sum_o), 64'(exp[31:0]));
        check({tag, "_carry"}, 64'(bus.carry_o), 64'(exp[32]));
        check({tag, "_ovf"}, 64'(bus.overflow_o), 64'(exp[33]));
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1 check({tag, "_drop"}, 64'(bus.valid_o), 64'd0);
    endtask

    initial begin
        logic [33:0] exp;
        int          lat, bad;
        logic [31:0] a, b;

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.add1_i  = '0;
        bus.add2_i  = '0;
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub_i   = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_sum", 64'(bus.sum_o), 64'd0);
        check("rst_carry", 64'(bus.carry_o), 64'd0);
        check("rst_ovf", 64'(bus.overflow_o), 64'd0);
        check("rst_ready_low", 64'(bus.ready_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_ready_high", 64'(bus.ready_o), 64'd1);

        run_add(32'h7fffffff, 32'h00000001, 1'b0, 0, "maxpos_p1");
        run_add(32'h80000000, 32'hffffffff, 1'b0, 0, "minneg_m1");
        run_add(32'd51, 32'hffffffc9, 1'b0, 0, "n51_m55");
        run_add(32'd50, 32'hffffffce, 1'b0, 0, "n50_m50");
        run_add(32'h88ca6c00, 32'hffffffe0, 1'b0, 0, "m2e9_m32");

        // Backpressure then a back-to-back hand-off from DONE.
        exp = model(32'd250, 32'd350, 1'b0);
        bus.ready_i = 1'b0;
        drive(32'd250, 32'd350);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd4);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.sum_o !== exp[31:0] || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_sum", 64'(bus.sum_o), 64'(exp[31:0]));
        exp = model(32'd13, 32'd7, 1'b0);
        bus.add1_i  = 32'd13;
        bus.add2_i  = 32'd7;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        #1 check("b2b_ready", 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        check("b2b_consumed", 64'(bus.valid_o), 64'd0);
        wait_valid(lat);
        check("b2b_lat", 64'(lat), 64'd4);
        check("b2b_sum", 64'(bus.sum_o), 64'(exp[31:0]));
        @(posedge clk);
        #1;

        // Reset in the second BUSY cycle must discard the transaction.
        drive(32'hffffff00, 32'd256);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_sum", 64'(bus.sum_o), 64'd0);
        check("midrst_carry", 64'(bus.carry_o), 64'd0);
        check("midrst_ovf", 64'(bus.overflow_o), 64'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0) bad++;
        end
        check("midrst_no_valid", 64'(bad), 64'd0);
        run_add(32'hfffffff3, 32'hfffffff9, 1'b0, 0, "after_rst");

`ifdef MULTICYCLE_ADDER_SUB_EN
        run_add(32'd13, 32'hfffffff9, 1'b1, 0, "sub_13_m7");
        run_add(32'h80000000, 32'd1, 1'b1, 0, "sub_min_1");
`endif

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                1: b = -a;
                2: b = {~a[31], 31'h7fffffff};
                default: ;
            endcase
`ifdef MULTICYCLE_ADDER_SUB_EN
            run_add(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd");
`else
            run_add(a, b, 1'b0, int'($urandom_range(0, 3)), "rnd");
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks, expected run to finish", n_checks);
        $fatal(1, "simulation time limit");
    end
endmodule
